// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request/lock inputs and sequenced reset outputs of reset_sequencer
`timescale 1ns/1ps

interface reset_sequencer_if #(
  parameter int CHANNELS = 4
);
  logic                ext_rst_req;
  logic                pll_locked;
  logic                pll_rst;
  logic [CHANNELS-1:0] rst_out;
  logic                done;
  logic [7:0]          retry_count;

  modport master (
    input  ext_rst_req,
    input  pll_locked,
    output pll_rst,
    output rst_out,
    output done,
    output retry_count
  );

  modport slave (
    output ext_rst_req,
    output pll_locked,
    input  pll_rst,
    input  rst_out,
    input  done,
    input  retry_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL reset, lock wait and in-order release of CHANNELS resets
// Optional lock watchdog enabled by defining RESET_SEQUENCER_WATCHDOG_EN.
`timescale 1ns/1ps

module reset_sequencer #(
  parameter int CHANNELS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STEP_DELAY     = 1024,
  parameter int LOCK_TIMEOUT   = 65535
) (
  input logic               clk,
  input logic               rst,
  reset_sequencer_if.master bus
);

  localparam int CNT_MAX = (PLL_RST_CYCLES > STEP_DELAY) ? PLL_RST_CYCLES : STEP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (CHANNELS < 1 || CHANNELS > 16 || SYNC_STAGES < 2 || PLL_RST_CYCLES < 1 ||
      STEP_DELAY < 1 || LOCK_TIMEOUT < 1) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, SEQ, RUN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [CHANNELS-1:0]    rst_out_q, rst_out_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic                   req_s, lock_s;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      retry_q, retry_d;
`endif

  assign req_s  = req_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  always_comb begin
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], bus.ext_rst_req};
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    state_d     = state_q;
    cnt_d       = '0;
    pll_rst_d   = pll_rst_q;
    rst_out_d   = rst_out_q;
    done_d      = done_q;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
    to_cnt_d    = '0;
    retry_d     = retry_q;
`endif
    if (req_s) begin
      state_d   = PLL_RST;
      pll_rst_d = 1'b1;
      rst_out_d = '1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        PLL_RST: begin
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_d   = WAIT_LOCK;
            pll_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = SEQ;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
          end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
            state_d   = PLL_RST;
            pll_rst_d = 1'b1;
            retry_d   = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
`endif
          end
        end
        SEQ: begin
          if (!lock_s) begin
            state_d   = WAIT_LOCK;
            rst_out_d = '1;
            done_d    = 1'b0;
          end else if (cnt_q == CNT_W'(STEP_DELAY - 1)) begin
            // Zeros shift in from bit 0, so channels release strictly in index order.
            rst_out_d = rst_out_q << 1;
            if (rst_out_d == '0) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d   = WAIT_LOCK;
            rst_out_d = '1;
            done_d    = 1'b0;
          end
        end
        default: begin
          state_d   = PLL_RST;
          pll_rst_d = 1'b1;
          rst_out_d = '1;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_out_q   <= '1;
      done_q      <= 1'b0;
      req_sync_q  <= '0;
      lock_sync_q <= '0;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
      to_cnt_q    <= '0;
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_q   <= rst_out_d;
      done_q      <= done_d;
      req_sync_q  <= req_sync_d;
      lock_sync_q <= lock_sync_d;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
      to_cnt_q    <= to_cnt_d;
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.pll_rst = pll_rst_q;
  assign bus.rst_out = rst_out_q;
  assign bus.done    = done_q;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  assign bus.retry_count = retry_q;
`else
  assign bus.retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed vector bench for reset_sequencer
`timescale 1ns/1ps

module tb_reset_sequencer;
  localparam int CH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.CHANNELS(CH)) bus ();

  reset_sequencer #(
    .CHANNELS(CH), .SYNC_STAGES(2), .PLL_RST_CYCLES(8), .STEP_DELAY(4), .LOCK_TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         cycles;
    logic       req;
    logic       lock;
    logic       exp_pll;
    logic [2:0] exp_rst;
    logic       exp_done;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input int n, input logic rq, input logic lk, input logic p,
                              input logic [2:0] r, input logic d, input string nm);
    tbl.push_back('{n, rq, lk, p, r, d, nm});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rst_out(input logic [2:0] v, input int max, input string name);
    int n = 0;
    while (bus.rst_out !== v && n < max) begin
      tick();
      n++;
    end
    check(name, {29'd0, bus.rst_out}, {29'd0, v});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    // Power-up sequence with lock already present.
    add(7, 0, 1, 1, 3'b111, 0, "t1_pll_rst");
    add(5, 0, 1, 0, 3'b111, 0, "t1_wait_seq");
    add(4, 0, 1, 0, 3'b110, 0, "t1_ch0");
    add(4, 0, 1, 0, 3'b100, 0, "t1_ch1");
    add(5, 0, 1, 0, 3'b000, 1, "t1_run");
    // Lock loss in RUN for 10 cycles, then relock.
    add(2, 0, 0, 0, 3'b000, 1, "t2_sync_delay");
    add(8, 0, 0, 0, 3'b111, 0, "t2_lost");
    add(6, 0, 1, 0, 3'b111, 0, "t2_relock");
    add(4, 0, 1, 0, 3'b110, 0, "t2_ch0");
    add(4, 0, 1, 0, 3'b100, 0, "t2_ch1");
    add(3, 0, 1, 0, 3'b000, 1, "t2_run");
    // One-cycle lock glitch to re-enter SEQ.
    add(1, 0, 0, 0, 3'b000, 1, "t3_glitch");
    add(1, 0, 1, 0, 3'b000, 1, "t3_glitch_sync");
    add(5, 0, 1, 0, 3'b111, 0, "t3_rewait");
    add(1, 0, 1, 0, 3'b110, 0, "t3_ch0");
    // 3-cycle external request mid-SEQ.
    add(2, 1, 1, 0, 3'b110, 0, "t3_req_sync");
    add(1, 1, 1, 1, 3'b111, 0, "t3_req_hit");
    add(9, 0, 1, 1, 3'b111, 0, "t3_pll_rst");
    add(5, 0, 1, 0, 3'b111, 0, "t3_wait_seq");
    add(4, 0, 1, 0, 3'b110, 0, "t3_ch0b");
    add(4, 0, 1, 0, 3'b100, 0, "t3_ch1b");
    add(2, 0, 1, 0, 3'b000, 1, "t3_run");

    bus.ext_rst_req = 1'b0;
    bus.pll_locked  = 1'b1;
    rst             = 1'b1;
    repeat (3) tick();
    check("reset_state", {21'd0, bus.pll_rst, bus.rst_out, bus.done, bus.retry_count},
          {21'd0, 1'b1, 3'b111, 1'b0, 8'd0});
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        bus.ext_rst_req = tbl[i].req;
        bus.pll_locked  = tbl[i].lock;
        tick();
        check(tbl[i].name, {27'd0, bus.pll_rst, bus.rst_out, bus.done},
              {27'd0, tbl[i].exp_pll, tbl[i].exp_rst, tbl[i].exp_done});
      end
    end

    // Asynchronous rst mid-SEQ.
    bus.pll_locked = 1'b0;
    wait_rst_out(3'b111, 10, "t6_lost");
    bus.pll_locked = 1'b1;
    wait_rst_out(3'b110, 20, "t6_in_seq");
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_rst", {21'd0, bus.pll_rst, bus.rst_out, bus.done, bus.retry_count},
          {21'd0, 1'b1, 3'b111, 1'b0, 8'd0});
    bus.pll_locked = 1'b0;
    tick();
    rst = 1'b0;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
    for (int k = 1; k <= 256 * 108; k++) begin
      tick();
      if (k == 107)
        check("t4_before_timeout", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b0, 8'd0});
      if (k == 108)
        check("t4_retry1", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b1, 8'd1});
      if (k == 116)
        check("t4_pll_rst_len", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b0, 8'd1});
      if (k == 216)
        check("t4_retry2", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b1, 8'd2});
      if (k == 324)
        check("t4_retry3", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b1, 8'd3});
      if (k == 255 * 108 - 1)
        check("t4_retry254", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b0, 8'd254});
      if (k == 255 * 108)
        check("t4_retry255", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b1, 8'd255});
      if (k == 256 * 108)
        check("t4_saturate", {23'd0, bus.pll_rst, bus.retry_count}, {23'd0, 1'b1, 8'd255});
    end
    bus.pll_locked = 1'b1;
    wait_rst_out(3'b000, 60, "t4_relock_seq");
    check("t4_relock_done", {31'd0, bus.done}, 32'd1);
`else
    repeat (10000) tick();
    check("t5_no_timeout", {20'd0, bus.pll_rst, bus.rst_out, bus.done, bus.retry_count},
          {20'd0, 1'b0, 3'b111, 1'b0, 8'd0});
    bus.pll_locked = 1'b1;
    repeat (14) tick();
    check("t5_seq_ch1", {28'd0, bus.rst_out, bus.done}, {28'd0, 3'b100, 1'b0});
    tick();
    check("t5_seq_done", {28'd0, bus.rst_out, bus.done}, {28'd0, 3'b000, 1'b1});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
